fetch_pair_issuer: RTL and testbench

- Fetch-side writer for the dual-write instruction FIFO. It generates the PC and drives an icache-style request/response handshake with one request outstanding at most.
- Each fetched pair is pushed into the FIFO through the write_en1/write_en2 interface, with addresses, instruction words and the inst_enF2 flag.
- Owns fifo_rst: it pulses it on every redirect (branch, exception or eret) so the FIFO drops wrong-path instructions.

---
 rtl/fetch_pair_issuer.sv | 208 ++++++++++++++++++++
 tb/tb_fetch_pair_issuer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pair_issuer.sv
// Fetch-side writer for the dual-write instruction FIFO: PC generation, icache handshake, FIFO pushes.
// Optional macro FETCH_ADEL_EN: misaligned PC produces a fetch-exception entry and halts fetch.
module fetch_pair_issuer #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        fifo_full,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata1,
   input  logic [31:0] inst_rdata2,
   output logic        fifo_rst,
   output logic        write_en1,
   output logic        write_en2,
   output logic [31:0] write_address1,
   output logic [31:0] write_address2,
   output logic [31:0] write_data1,
   output logic [31:0] write_data2,
   output logic        inst_enF2
);

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_WAIT    = 2'd1,
`ifdef FETCH_ADEL_EN
      S_DISCARD = 2'd2,
      S_HALT    = 2'd3
`else
      S_DISCARD = 2'd2
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] lat_pc_q, lat_pc_d;
   logic        lat_pair_q, lat_pair_d;
   logic        fifo_rst_q, fifo_rst_d;
   logic        we1_q, we1_d;
   logic        we2_q, we2_d;
   logic [31:0] wa1_q, wa1_d;
   logic [31:0] wa2_q, wa2_d;
   logic [31:0] wd1_q, wd1_d;
   logic [31:0] wd2_q, wd2_d;
   logic        enf2_q, enf2_d;
   logic        inst_req_s;
   logic [31:0] req_addr_s;
   logic        pair_s;

`ifdef FETCH_ADEL_EN
   logic        misaligned_s;
   assign misaligned_s = (pc_q[1:0] != 2'b00);
   assign req_addr_s   = pc_q;
`else
   assign req_addr_s   = pc_q & 32'hFFFF_FFFC;
`endif
   assign pair_s = ~req_addr_s[2];

   // Next-state, PC update and registered write-port decode
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      lat_pc_d   = lat_pc_q;
      lat_pair_d = lat_pair_q;
      fifo_rst_d = 1'b0;
      we1_d      = 1'b0;
      we2_d      = 1'b0;
      wa1_d      = 32'h0000_0000;
      wa2_d      = 32'h0000_0000;
      wd1_d      = 32'h0000_0000;
      wd2_d      = 32'h0000_0000;
      enf2_d     = 1'b0;
      inst_req_s = 1'b0;

      case (state_q)
         S_REQ: begin
`ifdef FETCH_ADEL_EN
            inst_req_s = !fifo_full && !redirect_valid && !misaligned_s;
`else
            inst_req_s = !fifo_full && !redirect_valid;
`endif
            if (redirect_valid) begin
               pc_d       = redirect_pc;
               fifo_rst_d = 1'b1;
               if (inst_addr_ok) begin
                  state_d = S_DISCARD;
               end else begin
                  state_d = S_REQ;
               end
            end
`ifdef FETCH_ADEL_EN
            else if (misaligned_s && !fifo_full) begin
               // Address-error entry: no request, one flagged write, then park
               we1_d   = 1'b1;
               wa1_d   = pc_q;
               enf2_d  = 1'b0;
               state_d = S_HALT;
            end
`endif
            else if (inst_req_s && inst_addr_ok) begin
               lat_pc_d   = req_addr_s;
               lat_pair_d = pair_s;
               pc_d       = req_addr_s + (pair_s ? 32'd8 : 32'd4);
               state_d    = S_WAIT;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_d       = redirect_pc;
               fifo_rst_d = 1'b1;
               if (inst_data_ok) begin
                  state_d = S_REQ;
               end else begin
                  state_d = S_DISCARD;
               end
            end else if (inst_data_ok) begin
               we1_d   = 1'b1;
               we2_d   = lat_pair_q;
               wa1_d   = lat_pc_q;
               wa2_d   = lat_pc_q + 32'd4;
               wd1_d   = inst_rdata1;
               wd2_d   = lat_pair_q ? inst_rdata2 : 32'h0000_0000;
               enf2_d  = 1'b1;
               state_d = S_REQ;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DISCARD: begin
            if (redirect_valid) begin
               pc_d       = redirect_pc;
               fifo_rst_d = 1'b1;
            end else begin
               pc_d = pc_q;
            end
            // A response arriving with the redirect still retires the stale request
            if (inst_data_ok) begin
               state_d = S_REQ;
            end else begin
               state_d = S_DISCARD;
            end
         end
`ifdef FETCH_ADEL_EN
         S_HALT: begin
            if (redirect_valid) begin
               pc_d       = redirect_pc;
               fifo_rst_d = 1'b1;
               state_d    = S_REQ;
            end else begin
               state_d = S_HALT;
            end
         end
`endif
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // State, PC and write-port registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         lat_pc_q   <= 32'h0000_0000;
         lat_pair_q <= 1'b0;
         fifo_rst_q <= 1'b0;
         we1_q      <= 1'b0;
         we2_q      <= 1'b0;
         wa1_q      <= 32'h0000_0000;
         wa2_q      <= 32'h0000_0000;
         wd1_q      <= 32'h0000_0000;
         wd2_q      <= 32'h0000_0000;
         enf2_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         lat_pc_q   <= lat_pc_d;
         lat_pair_q <= lat_pair_d;
         fifo_rst_q <= fifo_rst_d;
         we1_q      <= we1_d;
         we2_q      <= we2_d;
         wa1_q      <= wa1_d;
         wa2_q      <= wa2_d;
         wd1_q      <= wd1_d;
         wd2_q      <= wd2_d;
         enf2_q     <= enf2_d;
      end
   end

   assign inst_req       = inst_req_s & ~rst;
   assign inst_addr      = req_addr_s;
   assign fifo_rst       = fifo_rst_q;
   assign write_en1      = we1_q;
   assign write_en2      = we2_q;
   assign write_address1 = wa1_q;
   assign write_address2 = wa2_q;
   assign write_data1    = wd1_q;
   assign write_data2    = wd2_q;
   assign inst_enF2      = enf2_q;

endmodule

// File: tb/tb_fetch_pair_issuer.sv
// Scoreboard bench for fetch_pair_issuer: directed fetches, redirects, fifo_full stall.
// Define FETCH_ADEL_EN to also exercise the address-error path.
module tb_fetch_pair_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fifo_full;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata1;
   logic [31:0] inst_rdata2;
   logic        fifo_rst;
   logic        write_en1;
   logic        write_en2;
   logic [31:0] write_address1;
   logic [31:0] write_address2;
   logic [31:0] write_data1;
   logic [31:0] write_data2;
   logic        inst_enF2;

   always #5 clk = ~clk;

   fetch_pair_issuer #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fifo_full(fifo_full),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata1(inst_rdata1), .inst_rdata2(inst_rdata2),
      .fifo_rst(fifo_rst),
      .write_en1(write_en1), .write_en2(write_en2),
      .write_address1(write_address1), .write_address2(write_address2),
      .write_data1(write_data1), .write_data2(write_data2),
      .inst_enF2(inst_enF2)
   );

   typedef struct {
      bit          is_rst;
      logic        en2;
      logic [31:0] a1;
      logic [31:0] a2;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        enf2;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic exp_t mk_write(input logic [31:0] a, input logic [31:0] d1, input logic [31:0] d2);
      exp_t e;
      logic pair;
      pair   = ~a[2];
      e.is_rst = 1'b0;
      e.en2  = pair;
      e.a1   = a;
      e.a2   = a + 32'd4;
      e.d1   = d1;
      e.d2   = pair ? d2 : 32'h0;
      e.enf2 = 1'b1;
      return e;
   endfunction

   function automatic exp_t mk_rst();
      exp_t e;
      e.is_rst = 1'b1;
      e.en2 = 1'b0; e.a1 = 32'h0; e.a2 = 32'h0; e.d1 = 32'h0; e.d2 = 32'h0; e.enf2 = 1'b0;
      return e;
   endfunction

   // Monitor: every fifo_rst pulse or write must match the next scoreboard entry
   always @(negedge clk) begin
      if (!rst && (fifo_rst || write_en1 || write_en2)) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: fifo_rst=%b we1=%b we2=%b a1=%h with empty scoreboard",
                     fifo_rst, write_en1, write_en2, write_address1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk1("evt_fifo_rst", fifo_rst, e.is_rst);
            if (e.is_rst) begin
               chk1("no_write_on_rst", write_en1 | write_en2, 1'b0);
            end else begin
               chk1("write_en1", write_en1, 1'b1);
               chk1("write_en2", write_en2, e.en2);
               chk32("write_address1", write_address1, e.a1);
               chk32("write_address2", write_address2, e.a2);
               chk32("write_data1", write_data1, e.d1);
               chk32("write_data2", write_data2, e.d2);
               chk1("inst_enF2", inst_enF2, e.enf2);
            end
         end
      end
   end

   task automatic wait_req(input logic [31:0] exp_addr);
      int n;
      n = 0;
      #1;
      while (!inst_req && n < 30) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk1("inst_req_seen", inst_req, 1'b1);
      chk32("inst_addr", inst_addr, exp_addr);
   endtask

   task automatic grant();
      inst_addr_ok = 1'b1;
      @(negedge clk);
      inst_addr_ok = 1'b0;
   endtask

   task automatic respond(input int lat, input logic [31:0] d1, input logic [31:0] d2,
                          input bit push, input exp_t e);
      repeat (lat - 1) @(negedge clk);
      inst_data_ok = 1'b1;
      inst_rdata1  = d1;
      inst_rdata2  = d2;
      if (push) sb.push_back(e);
      @(negedge clk);
      inst_data_ok = 1'b0;
      inst_rdata1  = 32'hDEAD_0001;
      inst_rdata2  = 32'hDEAD_0002;
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] d1, input logic [31:0] d2);
      wait_req(a);
      grant();
      respond(1, d1, d2, 1'b1, mk_write(a, d1, d2));
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      sb.push_back(mk_rst());
      #1;
      chk1("req_blocked_by_redirect", inst_req, 1'b0);
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; fifo_full = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
      inst_rdata1 = 32'h0; inst_rdata2 = 32'h0;
      repeat (3) @(negedge clk);
      chk1("reset_inst_req", inst_req, 1'b0);
      chk1("reset_write_en1", write_en1, 1'b0);
      chk1("reset_write_en2", write_en2, 1'b0);
      chk1("reset_fifo_rst", fifo_rst, 1'b0);
      chk1("reset_inst_enF2", inst_enF2, 1'b0);
      rst = 1'b0;

      // Pair fetch from reset PC, then back-to-back next pair
      fetch(32'hBFC0_0000, 32'h0000_0011, 32'h0000_0022);
      fetch(32'hBFC0_0008, 32'h0000_0033, 32'h0000_0044);

      // Redirect to an odd-word address: single fetch
      redirect(32'h8000_0004);
      fetch(32'h8000_0004, 32'h0000_00AA, 32'h0000_00BB);

      // Redirect while waiting: response three cycles later is dropped
      wait_req(32'h8000_0008);
      grant();
      redirect(32'h8000_1000);
      repeat (1) @(negedge clk);
      respond(1, 32'h5555_5555, 32'h6666_6666, 1'b0, mk_rst());
      fetch(32'h8000_1000, 32'h0000_0101, 32'h0000_0102);

      // fifo_full stall for five cycles
      fifo_full = 1'b1;
      #1;
      chk1("full_req_0", inst_req, 1'b0);
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk1("full_req_n", inst_req, 1'b0);
      end
      @(negedge clk);
      fifo_full = 1'b0;
      #1;
      chk1("req_after_full", inst_req, 1'b1);
      fetch(32'h8000_1008, 32'h0000_0201, 32'h0000_0202);

      // Redirect and data_ok in the same WAIT cycle
      wait_req(32'h8000_1010);
      grant();
      inst_data_ok   = 1'b1;
      inst_rdata1    = 32'h7777_7777;
      inst_rdata2    = 32'h8888_8888;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_2000;
      sb.push_back(mk_rst());
      @(negedge clk);
      inst_data_ok   = 1'b0;
      redirect_valid = 1'b0;
      fetch(32'h8000_2000, 32'h0000_0301, 32'h0000_0302);

      // Second redirect while discarding
      wait_req(32'h8000_2008);
      grant();
      redirect(32'h8000_3000);
      redirect(32'h8000_4004);
      respond(1, 32'h9999_9999, 32'hAAAA_AAAA, 1'b0, mk_rst());
      fetch(32'h8000_4004, 32'h0000_0401, 32'h0000_0402);

`ifdef FETCH_ADEL_EN
      // Misaligned PC: exception entry, then halt until redirect
      begin
         exp_t e;
         redirect(32'h8000_0002);
         e.is_rst = 1'b0; e.en2 = 1'b0; e.a1 = 32'h8000_0002; e.a2 = 32'h0;
         e.d1 = 32'h0; e.d2 = 32'h0; e.enf2 = 1'b0;
         sb.push_back(e);
         for (int i = 0; i < 5; i++) begin
            #1;
            chk1("adel_no_req", inst_req, 1'b0);
            @(negedge clk);
         end
         redirect(32'h8000_0000);
         fetch(32'h8000_0000, 32'h0000_0501, 32'h0000_0502);
      end
`endif

      repeat (5) @(negedge clk);
      chk32("scoreboard_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
